ecc_field_alu: RTL and testbench

- Parametrised modular-arithmetic engine over GF(p) for the ECC datapath.
- Performs modular add, subtract, multiply and inverse on WIDTH-bit field elements using an en/done handshake.
- Point-add and point-double sequencers issue field operations through this block one at a time.
- Multiply is bit-serial interleaved; inverse is binary extended Euclid. Neither needs a hardware multiplier or divider.

---
 rtl/ecc_field_alu.sv | 244 ++++++++++++++++++++++++
 tb/tb_ecc_field_alu.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ecc_field_alu.sv
`default_nettype none
// ============================================================================
// Module   : ecc_field_alu
// Brief    : GF(p) add/sub/mul/inv engine with en/done handshake; modular
//            inverse is built only when ECC_FIELD_ALU_INV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ecc_field_alu #(
    parameter int unsigned      WIDTH   = 64,
    parameter logic [WIDTH-1:0] MODULUS = 64'd10997031918897188677
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_en,
    input  logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_P,
    input  logic [WIDTH-1:0] alu_Q,
    output logic [WIDTH-1:0] alu_R,
    output logic             alu_done,
    output logic             alu_err,
    output logic             alu_busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_ADDSUB = 3'd2;
    localparam logic [2:0] S_MUL    = 3'd3;
`ifdef ECC_FIELD_ALU_INV_EN
    localparam logic [2:0] S_INV    = 3'd4;
`endif
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [1:0] c_OP_ADD = 2'd0;
    localparam logic [1:0] c_OP_SUB = 2'd1;
    localparam logic [1:0] c_OP_MUL = 2'd2;
    localparam logic [1:0] c_OP_INV = 2'd3;

    localparam int unsigned      c_CW       = $clog2(2 * WIDTH + 1);
    localparam logic [WIDTH:0]   c_M1       = {1'b0, MODULUS};
    localparam logic [WIDTH+1:0] c_M2       = {2'b00, MODULUS};
    localparam logic [c_CW-1:0]  c_MUL_LAST = c_CW'(WIDTH - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_n;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_err;
    logic             w_check_err;

    // True result is always below MODULUS, so wrapping in WIDTH bits is exact.
    function automatic logic [WIDTH-1:0] f_modsub(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        return (a >= b) ? (a - b) : (a - b + MODULUS);
    endfunction

    // ---------------- add / sub ----------------
    logic [WIDTH:0]   w_add_s;
    logic [WIDTH-1:0] w_add_r;
    logic [WIDTH-1:0] w_sub_r;

    assign w_add_s = {1'b0, r_a} + {1'b0, r_b};
    assign w_add_r = (w_add_s >= c_M1) ? WIDTH'(w_add_s - c_M1) : w_add_s[WIDTH-1:0];
    assign w_sub_r = f_modsub(r_a, r_b);

    // ---------------- interleaved multiply step (r_b shifts MSB-first) ----------------
    logic [WIDTH+1:0] w_dbl;
    logic [WIDTH+1:0] w_dbl_r;
    logic [WIDTH+1:0] w_sum;
    logic [WIDTH-1:0] w_mul_next;

    assign w_dbl      = {1'b0, r_acc, 1'b0};
    assign w_dbl_r    = (w_dbl >= c_M2) ? (w_dbl - c_M2) : w_dbl;
    assign w_sum      = w_dbl_r + (r_b[WIDTH-1] ? {2'b00, r_a} : '0);
    assign w_mul_next = (w_sum >= c_M2) ? WIDTH'(w_sum - c_M2) : w_sum[WIDTH-1:0];

`ifdef ECC_FIELD_ALU_INV_EN
    // ---------------- binary extended Euclid ----------------
    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);
    localparam logic [c_CW-1:0]  c_INV_MAX = c_CW'(2 * WIDTH);

    logic [WIDTH-1:0] r_u, r_v, r_x1, r_x2;
    logic [WIDTH-1:0] w_u_n, w_v_n, w_x1_n, w_x2_n;

    function automatic logic [WIDTH-1:0] f_half(input logic [WIDTH-1:0] x);
        return x[0] ? WIDTH'(({1'b0, x} + c_M1) >> 1) : (x >> 1);
    endfunction

    // A subtract of two odd values is always even, so it is halved in the same
    // step; each step then shrinks u*v by at least 2, keeping steps <= 2*WIDTH.
    always_comb begin
        w_u_n  = r_u;
        w_v_n  = r_v;
        w_x1_n = r_x1;
        w_x2_n = r_x2;
        if (!r_u[0]) begin
            w_u_n  = r_u >> 1;
            w_x1_n = f_half(r_x1);
        end else if (!r_v[0]) begin
            w_v_n  = r_v >> 1;
            w_x2_n = f_half(r_x2);
        end else if (r_u >= r_v) begin
            w_u_n  = (r_u - r_v) >> 1;
            w_x1_n = f_half(f_modsub(r_x1, r_x2));
        end else begin
            w_v_n  = (r_v - r_u) >> 1;
            w_x2_n = f_half(f_modsub(r_x2, r_x1));
        end
    end
`endif

    always_comb begin
        w_check_err = (r_a >= MODULUS);
        if (r_op == c_OP_INV) begin
`ifdef ECC_FIELD_ALU_INV_EN
            if (r_a == '0) w_check_err = 1'b1;
`else
            w_check_err = 1'b1;
`endif
        end else if (r_b >= MODULUS) begin
            w_check_err = 1'b1;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_n;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:   if (alu_en) w_state_n = S_CHECK;
            S_CHECK: begin
                if (w_check_err) begin
                    w_state_n = S_DONE;
                end else begin
                    case (r_op)
                        c_OP_ADD, c_OP_SUB: w_state_n = S_ADDSUB;
                        c_OP_MUL:           w_state_n = S_MUL;
`ifdef ECC_FIELD_ALU_INV_EN
                        default:            w_state_n = S_INV;
`else
                        default:            w_state_n = S_DONE;
`endif
                    endcase
                end
            end
            S_ADDSUB: w_state_n = S_DONE;
            S_MUL:    if (r_cnt == c_MUL_LAST) w_state_n = S_DONE;
`ifdef ECC_FIELD_ALU_INV_EN
            S_INV:    if (r_u == c_ONE || r_v == c_ONE || r_cnt == c_INV_MAX) w_state_n = S_DONE;
`endif
            S_DONE:   w_state_n = S_IDLE;
            default:  w_state_n = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        alu_done = (r_state == S_DONE);
        alu_busy = (r_state != S_IDLE);
    end

    assign alu_R   = r_result;
    assign alu_err = r_err;

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
`ifdef ECC_FIELD_ALU_INV_EN
            r_u      <= '0;
            r_v      <= '0;
            r_x1     <= '0;
            r_x2     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (alu_en) begin
                        r_op  <= alu_op;
                        r_a   <= alu_P;
                        r_b   <= alu_Q;
                        r_err <= 1'b0;
                    end
                end
                S_CHECK: begin
                    r_acc <= '0;
                    r_cnt <= '0;
`ifdef ECC_FIELD_ALU_INV_EN
                    r_u   <= r_a;
                    r_v   <= MODULUS;
                    r_x1  <= c_ONE;
                    r_x2  <= '0;
`endif
                    if (w_check_err) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end
                end
                S_ADDSUB: r_result <= (r_op == c_OP_ADD) ? w_add_r : w_sub_r;
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_b   <= r_b << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_MUL_LAST) r_result <= w_mul_next;
                end
`ifdef ECC_FIELD_ALU_INV_EN
                S_INV: begin
                    if (r_u == c_ONE) begin
                        r_result <= r_x1;
                    end else if (r_v == c_ONE) begin
                        r_result <= r_x2;
                    end else if (r_cnt == c_INV_MAX) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end else begin
                        r_u   <= w_u_n;
                        r_v   <= w_v_n;
                        r_x1  <= w_x1_n;
                        r_x2  <= w_x2_n;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ecc_field_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_field_alu
// Brief    : Directed self-checking bench for ecc_field_alu (8-bit/251 and
//            default 64-bit instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecc_field_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  op;
    logic [7:0]  p, q, r;
    logic        done, err, busy;
    logic        en64;
    logic [1:0]  op64;
    logic [63:0] p64, q64, r64;
    logic        done64, err64, busy64;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ecc_field_alu #(.WIDTH(8), .MODULUS(8'd251)) dut (
        .clk(clk), .rst(rst), .alu_en(en), .alu_op(op), .alu_P(p), .alu_Q(q),
        .alu_R(r), .alu_done(done), .alu_err(err), .alu_busy(busy)
    );

    ecc_field_alu dut64 (
        .clk(clk), .rst(rst), .alu_en(en64), .alu_op(op64), .alu_P(p64), .alu_Q(q64),
        .alu_R(r64), .alu_done(done64), .alu_err(err64), .alu_busy(busy64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // elat < 0 means "done within 18 edges of the accept edge".
    task automatic run8(input string tag, input logic [1:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input logic ee,
                        input int elat);
        int n;
        bit seen;
        bit busy_ok;
        op = o; p = a; q = b; en = 1'b1;
        tick();
        en = 1'b0;
        n = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && n < 200) begin
            if (done) seen = 1'b1;
            else begin
                if (!busy) busy_ok = 1'b0;
                tick();
                n++;
            end
        end
        chk({tag, "_seen"}, 64'(seen), 64'd1);
        if (elat >= 0) chk({tag, "_lat"}, 64'(n), 64'(elat));
        else           chk({tag, "_lat_le18"}, 64'(n <= 18), 64'd1);
        chk({tag, "_R"}, 64'(r), 64'(er));
        chk({tag, "_err"}, 64'(err), 64'(ee));
        chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
        tick();
        chk({tag, "_one_pulse"}, 64'({done, busy}), 64'd0);
    endtask

    initial begin
        int n;
        int cnt;
        rst = 1'b1; en = 1'b0; op = '0; p = '0; q = '0;
        en64 = 1'b0; op64 = '0; p64 = '0; q64 = '0;
        repeat (3) tick();
        chk("rst_R",    64'(r),    64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err",  64'(err),  64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst64_R",  r64,       64'd0);
        rst = 1'b0;
        tick();

        run8("add_wrap",    2'd0, 8'd200, 8'd100, 8'd49,  1'b0, 2);
        run8("add_eq_m",    2'd0, 8'd250, 8'd1,   8'd0,   1'b0, 2);
        run8("sub_borrow",  2'd1, 8'd5,   8'd9,   8'd247, 1'b0, 2);
        run8("sub_plain",   2'd1, 8'd9,   8'd5,   8'd4,   1'b0, 2);
        run8("mul_17_23",   2'd2, 8'd17,  8'd23,  8'd140, 1'b0, 9);
        run8("mul_250_250", 2'd2, 8'd250, 8'd250, 8'd1,   1'b0, 9);
`ifdef ECC_FIELD_ALU_INV_EN
        run8("inv_3",       2'd3, 8'd3,   8'd0,   8'd84,  1'b0, -1);
        run8("inv_1",       2'd3, 8'd1,   8'd0,   8'd1,   1'b0, -1);
        run8("inv_0",       2'd3, 8'd0,   8'd0,   8'd0,   1'b1, 1);
`else
        run8("inv_off",     2'd3, 8'd3,   8'd0,   8'd0,   1'b1, 1);
`endif
        run8("range_p",     2'd0, 8'd251, 8'd1,   8'd0,   1'b1, 1);
        run8("range_clear", 2'd0, 8'd1,   8'd2,   8'd3,   1'b0, 2);
        run8("range_q",     2'd1, 8'd1,   8'd255, 8'd0,   1'b1, 1);
        run8("mul_again",   2'd2, 8'd17,  8'd23,  8'd140, 1'b0, 9);

        // reset in the middle of a multiply
        op = 2'd2; p = 8'd17; q = 8'd23; en = 1'b1;
        tick();
        en = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_R",    64'(r),    64'd0);
        chk("abort_done", 64'(done), 64'd0);
        cnt = 0;
        repeat (20) begin
            if (done) cnt++;
            tick();
        end
        chk("abort_no_done", 64'(cnt), 64'd0);

        // en held high through busy and the done cycle
        op = 2'd2; p = 8'd17; q = 8'd23; en = 1'b1;
        tick();
        op = 2'd0; p = 8'd1; q = 8'd1;
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        chk("ov_lat", 64'(n), 64'd9);
        chk("ov_R",   64'(r), 64'd140);
        tick();
        chk("ov_done_not_accepted", 64'(busy), 64'd0);
        en = 1'b0;
        cnt = 0;
        repeat (15) begin
            if (done) cnt++;
            tick();
        end
        chk("ov_extra_done", 64'(cnt), 64'd0);

        // default 64-bit parameters
        op64 = 2'd2; p64 = 64'd93; q64 = 64'd8626; en64 = 1'b1;
        tick();
        en64 = 1'b0;
        n = 0;
        while (!done64 && n < 300) begin
            tick();
            n++;
        end
        chk("mul64_lat", 64'(n), 64'd65);
        chk("mul64_R",   r64,    64'd802218);
        chk("mul64_err", 64'(err64), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
